// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: funct3 encodings, load fault causes,
// load FSM states and the load legality/alignment classifier.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } ld_state_t;

    // Classify a load at accept time; illegal encodings take precedence
    // over alignment since an unknown funct3 has no defined access size.
    function automatic logic [1:0] load_check(input logic [2:0] f3,
                                              input logic [1:0] offset);
        logic [1:0] cause;
        cause = CAUSE_NONE;
        case (f3)
            F3_LB, F3_LBU: cause = CAUSE_NONE;
            F3_LH, F3_LHU: cause = offset[0] ? CAUSE_MISALIGN : CAUSE_NONE;
            F3_LW:         cause = (offset != 2'b00) ? CAUSE_MISALIGN : CAUSE_NONE;
            default:       cause = CAUSE_ILLEGAL;
        endcase
        return cause;
    endfunction

endpackage

// File: rtl/load_align_extend.sv
// Selects the addressed byte/halfword of a read word and sign- or
// zero-extends it according to the load funct3. Purely combinational.
module load_align_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    // Lane select followed by extension; LW and unknown encodings pass the word.
    always_comb begin
        byte_sel = 8'sd0;
        half_sel = 16'sd0;
        result   = word;
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   result = 32'(byte_sel);
            F3_LBU:  result = {24'd0, byte_sel};
            F3_LH:   result = 32'(half_sel);
            F3_LHU:  result = {16'd0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load unit: accepts one load, issues a word-aligned read, waits for data
// (bounded by a timeout) and returns an extended writeback or a fault pulse.
module load_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] instruction_data,
    input  logic [31:0] data_address,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        ld_fault,
    output logic [1:0]  ld_fault_cause
);

    ld_state_t        state;
    logic [CNT_W-1:0] wait_cnt;
    logic [2:0]       f3_q;
    logic [4:0]       rd_q;
    logic [1:0]       off_q;
    logic [1:0]       accept_cause;
    logic [31:0]      ext_result;
    logic             unused_insn_bits;

    assign unused_insn_bits = ^{instruction_data[31:15], instruction_data[6:0]};

    // Ready is a pure function of state so upstream sees it without delay.
    always_comb begin
        ld_ready     = (state == ST_IDLE);
        accept_cause = load_check(instruction_data[14:12], data_address[1:0]);
    end

    // Extraction works on the live read bus so the result can be registered
    // on the same edge that the data arrives.
    load_align_extend u_align (
        .word   (mem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .result (ext_result)
    );

    // Load FSM with registered memory request and writeback/fault outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            f3_q           <= 3'd0;
            rd_q           <= 5'd0;
            off_q          <= 2'd0;
            mem_req        <= 1'b0;
            mem_addr       <= 32'd0;
            wb_valid       <= 1'b0;
            wb_rd          <= 5'd0;
            wb_data        <= 32'd0;
            ld_fault       <= 1'b0;
            ld_fault_cause <= CAUSE_NONE;
        end else begin
            wb_valid       <= 1'b0;
            ld_fault       <= 1'b0;
            ld_fault_cause <= CAUSE_NONE;
            case (state)
                ST_IDLE: begin
                    if (ld_valid) begin
                        f3_q  <= instruction_data[14:12];
                        rd_q  <= instruction_data[11:7];
                        off_q <= data_address[1:0];
                        if (accept_cause != CAUSE_NONE) begin
                            state          <= ST_FAULT;
                            ld_fault       <= 1'b1;
                            ld_fault_cause <= accept_cause;
                        end else begin
                            state    <= ST_REQ;
                            mem_req  <= 1'b1;
                            mem_addr <= {data_address[31:2], 2'b00};
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_rvalid) begin
                            state    <= ST_DONE;
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_q;
                            wb_data  <= ext_result;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        state    <= ST_DONE;
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        wb_data  <= ext_result;
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state          <= ST_FAULT;
                        ld_fault       <= 1'b1;
                        ld_fault_cause <= CAUSE_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                ST_FAULT: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule
